// File: rtl/ball_motion_ctrl.sv
// Per-frame bouncing-ball physics: fixed-point motion, gravity, wall/floor/ceiling bounces, hit/split handling.
// Optional BALL_PAUSE_EN adds a pause input that freezes frame updates while hits stay live.
module ball_motion_ctrl #(
    parameter int FP_BITS     = 6,
    parameter int SPEED_X     = 64,
    parameter int GRAVITY     = 4,
    parameter int MAX_VY      = 1024,
    parameter int BOUNCE_BASE = 384,
    parameter int BOUNCE_STEP = 128,
    parameter int POP_SPEED   = 256,
    parameter int BASE_SIZE   = 32,
    parameter int MAX_SHIFT   = 2,
    parameter int SCREEN_W    = 640,
    parameter int FLOOR_Y     = 440,
    parameter int INIT_X      = 100,
    parameter int INIT_Y      = 100
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
`ifdef BALL_PAUSE_EN
    input  logic        pause,
`endif
    input  logic        launch,
    input  logic [10:0] launch_x,
    input  logic [10:0] launch_y,
    input  logic [2:0]  launch_shift,
    input  logic        launch_right,
    input  logic        hit,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic [2:0]  size_shift,
    output logic        active,
    output logic        popped,
    output logic        split_req,
    output logic [2:0]  split_shift,
    output logic        split_right
);

    localparam int unsigned PW = 18;
    localparam int unsigned VW = 12;
    localparam int unsigned XW = 11;
    localparam int unsigned SW = 3;

    localparam logic signed [VW-1:0] VX_POS   = VW'(SPEED_X);
    localparam logic signed [VW-1:0] VX_NEG   = VW'(-SPEED_X);
    localparam logic signed [VW-1:0] VY_POP   = VW'(-POP_SPEED);
    localparam logic signed [VW:0]   VY_MAX   = (VW+1)'(MAX_VY);
    localparam logic signed [VW:0]   VY_MIN   = (VW+1)'(-MAX_VY);
    localparam logic signed [VW:0]   GRAV     = (VW+1)'(GRAVITY);
    localparam logic [SW-1:0]        SHIFT_MX = SW'(MAX_SHIFT);
    localparam logic signed [PW-1:0] POS_X0   = PW'(INIT_X * (2 ** FP_BITS));
    localparam logic signed [PW-1:0] POS_Y0   = PW'(INIT_Y * (2 ** FP_BITS));

    typedef enum logic [1:0] {IDLE, ACTIVE, POP} state_t;

    state_t               state_q, state_d;
    logic signed [PW-1:0] pos_x_q, pos_y_q, pos_x_d, pos_y_d;
    logic signed [VW-1:0] vel_x_q, vel_y_q, vel_x_d, vel_y_d;
    logic [SW-1:0]        shift_d, split_shift_d;
    logic                 active_d, popped_d, split_req_d, split_right_d;
    logic                 frame_tick;

    logic signed [VW:0]   vy_sum;
    logic signed [PW-1:0] edge_px, lim_x, lim_y;
    logic [VW-1:0]        bounce_mag;

`ifdef BALL_PAUSE_EN
    assign frame_tick = startOfFrame & ~pause;
`else
    assign frame_tick = startOfFrame;
`endif

    // Next-state, motion update and output pulses
    always_comb begin
        state_d       = state_q;
        pos_x_d       = pos_x_q;
        pos_y_d       = pos_y_q;
        vel_x_d       = vel_x_q;
        vel_y_d       = vel_y_q;
        shift_d       = size_shift;
        active_d      = active;
        popped_d      = 1'b0;
        split_req_d   = 1'b0;
        split_shift_d = split_shift;
        split_right_d = split_right;

        edge_px    = PW'(BASE_SIZE) <<< size_shift;
        lim_x      = (PW'(SCREEN_W) - edge_px) <<< FP_BITS;
        lim_y      = (PW'(FLOOR_Y) - edge_px) <<< FP_BITS;
        bounce_mag = VW'(BOUNCE_BASE) + VW'(BOUNCE_STEP) * VW'(size_shift);
        vy_sum     = (VW+1)'(vel_y_q) + GRAV;

        unique case (state_q)
            IDLE: begin
                active_d = 1'b0;
                if (launch) begin
                    pos_x_d  = $signed(PW'(launch_x) << FP_BITS);
                    pos_y_d  = $signed(PW'(launch_y) << FP_BITS);
                    vel_x_d  = launch_right ? VX_POS : VX_NEG;
                    vel_y_d  = '0;
                    shift_d  = (launch_shift > SHIFT_MX) ? SHIFT_MX : launch_shift;
                    active_d = 1'b1;
                    state_d  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (hit) begin
                    popped_d = 1'b1;
                    if (size_shift != '0) begin
                        shift_d       = size_shift - SW'(1);
                        vel_y_d       = VY_POP;
                        split_req_d   = 1'b1;
                        split_shift_d = size_shift - SW'(1);
                        split_right_d = vel_x_q[VW-1];
                        state_d       = POP;
                    end else begin
                        active_d = 1'b0;
                        state_d  = IDLE;
                    end
                end else if (frame_tick) begin
                    if (vy_sum > VY_MAX)      vel_y_d = VW'(VY_MAX);
                    else if (vy_sum < VY_MIN) vel_y_d = VW'(VY_MIN);
                    else                      vel_y_d = VW'(vy_sum);
                    pos_x_d = pos_x_q + PW'(vel_x_q);
                    pos_y_d = pos_y_q + PW'(vel_y_d);
                    if (pos_x_d < 0) begin
                        pos_x_d = '0;
                        vel_x_d = VX_POS;
                    end else if (pos_x_d > lim_x) begin
                        pos_x_d = lim_x;
                        vel_x_d = VX_NEG;
                    end
                    if (pos_y_d < 0) begin
                        pos_y_d = '0;
                        vel_y_d = (vel_y_d < 0) ? -vel_y_d : vel_y_d;
                    end else if (pos_y_d > lim_y) begin
                        pos_y_d = lim_y;
                        vel_y_d = -$signed(bounce_mag);
                    end
                end
            end
            POP: begin
                // One frame of immunity: hits ignored, no motion on the return tick
                if (frame_tick) state_d = ACTIVE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            pos_x_q     <= POS_X0;
            pos_y_q     <= POS_Y0;
            vel_x_q     <= '0;
            vel_y_q     <= '0;
            topLeftX    <= XW'(INIT_X);
            topLeftY    <= XW'(INIT_Y);
            size_shift  <= '0;
            active      <= 1'b0;
            popped      <= 1'b0;
            split_req   <= 1'b0;
            split_shift <= '0;
            split_right <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            vel_x_q     <= vel_x_d;
            vel_y_q     <= vel_y_d;
            topLeftX    <= XW'(pos_x_d >>> FP_BITS);
            topLeftY    <= XW'(pos_y_d >>> FP_BITS);
            size_shift  <= shift_d;
            active      <= active_d;
            popped      <= popped_d;
            split_req   <= split_req_d;
            split_shift <= split_shift_d;
            split_right <= split_right_d;
        end
    end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Scoreboard bench for ball_motion_ctrl: an integer physics model predicts outputs per driven event.
module tb_ball_motion_ctrl;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame, launch, launch_right, hit;
    logic [10:0] launch_x, launch_y;
    logic [2:0]  launch_shift;
    logic [10:0] topLeftX, topLeftY;
    logic [2:0]  size_shift, split_shift;
    logic        active, popped, split_req, split_right;
`ifdef BALL_PAUSE_EN
    logic        pause = 1'b0;
`endif

    ball_motion_ctrl dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
`ifdef BALL_PAUSE_EN
        .pause(pause),
`endif
        .launch(launch), .launch_x(launch_x), .launch_y(launch_y),
        .launch_shift(launch_shift), .launch_right(launch_right), .hit(hit),
        .topLeftX(topLeftX), .topLeftY(topLeftY), .size_shift(size_shift),
        .active(active), .popped(popped), .split_req(split_req),
        .split_shift(split_shift), .split_right(split_right)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x, y, sh, act, pop, sreq, sshift, sright;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: positions/velocities in subpixels, state 0=idle 1=active 2=pop
    int mx, my, mvx, mvy, msh, mst, mact, ssh, srt;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mx = 100 * 64; my = 100 * 64; mvx = 0; mvy = 0;
        msh = 0; mst = 0; mact = 0; ssh = 0; srt = 0;
    endtask

    task automatic model_event(input bit sof, input bit h, input bit l,
                               input int lx, input int ly, input int ls, input bit lr,
                               output exp_t e);
        int s;
        int pop = 0;
        int sreq = 0;
        if (mst == 1 && h) begin
            pop = 1;
            if (msh > 0) begin
                msh--; mvy = -256; sreq = 1; ssh = msh; srt = (mvx < 0); mst = 2;
            end else begin
                mact = 0; mst = 0;
            end
        end else if (mst == 0 && l) begin
            mx = lx * 64; my = ly * 64; mvx = lr ? 64 : -64; mvy = 0;
            msh = (ls > 2) ? 2 : ls; mst = 1; mact = 1;
        end else if (sof && mst == 2) begin
            mst = 1;
        end else if (sof && mst == 1) begin
            s = 32 << msh;
            mvy = mvy + 4;
            if (mvy > 1024) mvy = 1024;
            if (mvy < -1024) mvy = -1024;
            mx = mx + mvx;
            my = my + mvy;
            if (mx < 0) begin mx = 0; mvx = 64; end
            else if (mx > (640 - s) * 64) begin mx = (640 - s) * 64; mvx = -64; end
            if (my < 0) begin my = 0; mvy = (mvy < 0) ? -mvy : mvy; end
            else if (my > (440 - s) * 64) begin my = (440 - s) * 64; mvy = -(384 + msh * 128); end
        end
        e.x = mx >>> 6; e.y = my >>> 6; e.sh = msh; e.act = mact;
        e.pop = pop; e.sreq = sreq; e.sshift = ssh; e.sright = srt;
    endtask

    task automatic apply(input bit sof, input bit h, input bit l,
                         input int lx = 0, input int ly = 0, input int ls = 0, input bit lr = 1'b0);
        exp_t e;
        @(negedge clk);
        startOfFrame = sof; hit = h; launch = l;
        launch_x = 11'(lx); launch_y = 11'(ly); launch_shift = 3'(ls); launch_right = lr;
        model_event(sof, h, l, lx, ly, ls, lr, e);
        sb.push_back(e);
        @(negedge clk);
        startOfFrame = 1'b0; hit = 1'b0; launch = 1'b0;
        if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("x",      int'(topLeftX),   e.x);
            chk("y",      int'(topLeftY),   e.y);
            chk("shift",  int'(size_shift), e.sh);
            chk("active", int'(active),     e.act);
            chk("popped", int'(popped),     e.pop);
            chk("split",  int'(split_req),  e.sreq);
            if (e.sreq != 0) begin
                chk("split_shift", int'(split_shift), e.sshift);
                chk("split_right", int'(split_right), e.sright);
            end
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) apply(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; launch = 1'b0; hit = 1'b0;
        launch_x = '0; launch_y = '0; launch_shift = '0; launch_right = 1'b0;
        model_reset();
        #12;
        chk("rst_x",      int'(topLeftX),  100);
        chk("rst_y",      int'(topLeftY),  100);
        chk("rst_shift",  int'(size_shift), 0);
        chk("rst_active", int'(active),    0);
        chk("rst_popped", int'(popped),    0);
        chk("rst_split",  int'(split_req), 0);
        @(negedge clk);
        resetN = 1'b1;

        // Hit while idle is ignored; launch and free flight
        apply(1'b0, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 100, 100, 0, 1'b1);
        frames(1);
        chk("tp_x1", int'(topLeftX), 101);
        chk("tp_y1", int'(topLeftY), 100);
        frames(15);
        chk("tp_x16", int'(topLeftX), 116);
        chk("tp_y16", int'(topLeftY), 108);

        // Shift-0 hit coincident with a frame: dies, no split, no motion
        apply(1'b1, 1'b1, 1'b0);
        chk("tp_die_pop",   int'(popped),    1);
        chk("tp_die_act",   int'(active),    0);
        chk("tp_die_split", int'(split_req), 0);
        chk("tp_die_x",     int'(topLeftX),  116);
        chk("tp_die_y",     int'(topLeftY),  108);

        // Right wall
        apply(1'b0, 1'b0, 1'b1, 600, 100, 0, 1'b1);
        frames(8);
        chk("tp_rw8", int'(topLeftX), 608);
        frames(1);
        chk("tp_rw9", int'(topLeftX), 608);
        frames(1);
        chk("tp_rw10", int'(topLeftX), 607);
        apply(1'b0, 1'b1, 1'b0);

        // Floor bounce for the largest ball
        apply(1'b0, 1'b0, 1'b1, 100, 300, 2, 1'b1);
        frames(19);
        chk("tp_fl19", int'(topLeftY), 311);
        frames(1);
        chk("tp_fl20", int'(topLeftY), 312);
        frames(1);
        chk("tp_fl21", int'(topLeftY), 302);

        // Launch while flying is ignored
        apply(1'b0, 1'b0, 1'b1, 10, 10, 0, 1'b0);

        // Split, immunity, then upward pop speed
        apply(1'b0, 1'b1, 1'b0);
        chk("tp_sp_pop",   int'(popped),      1);
        chk("tp_sp_req",   int'(split_req),   1);
        chk("tp_sp_shift", int'(split_shift), 1);
        chk("tp_sp_right", int'(split_right), 0);
        chk("tp_sp_size",  int'(size_shift),  1);
        apply(1'b0, 1'b1, 1'b0);
        chk("tp_imm_pop",  int'(popped),     0);
        chk("tp_imm_size", int'(size_shift), 1);
        frames(1);
        chk("tp_imm_y", int'(topLeftY), 302);
        frames(1);
        chk("tp_pop_y", int'(topLeftY), 298);
        frames(5);

        // Asynchronous reset mid-flight
        @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_x",   int'(topLeftX), 100);
        chk("mid_rst_y",   int'(topLeftY), 100);
        chk("mid_rst_act", int'(active),   0);
        @(negedge clk);
        resetN = 1'b1;
        apply(1'b0, 1'b0, 1'b1, 200, 50, 5, 1'b0);
        chk("tp_sat_shift", int'(size_shift), 2);
        frames(3);
        apply(1'b0, 1'b1, 1'b0);
        chk("tp_sp_right_l", int'(split_right), 1);
        frames(2);
        apply(1'b0, 1'b1, 1'b0);
        frames(2);
        apply(1'b0, 1'b1, 1'b0);

        // Left wall
        apply(1'b0, 1'b0, 1'b1, 2, 100, 1, 1'b0);
        frames(3);
        chk("tp_lw3", int'(topLeftX), 0);
        frames(1);
        chk("tp_lw4", int'(topLeftX), 1);
        frames(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
